// File: rtl/regfile_pkg.sv
// regfile_pkg: default configuration constants and word/address typedefs for the register file.
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 1;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    typedef logic [XLEN_DEF-1:0] word_t;
    typedef logic [AW_DEF-1:0]   addr_t;
endpackage

// File: rtl/regfile_wr_merge.sv
// regfile_wr_merge: per-register next data, write hit and next busy from all write ports and alloc.
// Ports: wr_en/wr_addr/wr_data (NWR write ports), alloc_en/alloc_addr, busy (current busy bits);
//        wdata/hit (winning write data and write strobe per register), busy_nxt (post-update busy).
module regfile_wr_merge #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = 5
) (
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR-1:0][AW-1:0]      wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]    wr_data,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_addr,
    input  logic [NREGS-1:0]            busy,
    output logic [NREGS-1:0][XLEN-1:0]  wdata,
    output logic [NREGS-1:0]            hit,
    output logic [NREGS-1:0]            busy_nxt
);
    // Matching against each register index means addresses >= NREGS never hit anything.
    // Later ports overwrite earlier ones, so the highest-indexed port wins; alloc is applied last.
    always_comb begin
        wdata    = '0;
        hit      = '0;
        busy_nxt = busy;
        for (int r = 0; r < NREGS; r++) begin
            if (!(ZERO_REG != 0 && r == 0)) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && wr_addr[w] == AW'(r)) begin
                        wdata[r]    = wr_data[w];
                        hit[r]      = 1'b1;
                        busy_nxt[r] = 1'b0;
                    end
                end
                if (alloc_en && alloc_addr == AW'(r)) busy_nxt[r] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, optional bypass/zero register and busy scoreboard.
// Ports: clk, rst_n (async active-low); rd_en/rd_addr -> rd_data/rd_busy (NRD registered read ports);
//        wr_en/wr_addr/wr_data (NWR write ports); alloc_en/alloc_addr (mark register busy).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int NWR      = NWR_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NRD-1:0]            rd_en,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][AW-1:0]    wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_addr
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0][XLEN-1:0] wdata;
    logic [NREGS-1:0]           hit;
    logic [NREGS-1:0]           busy_nxt;
    logic [NRD-1:0][XLEN-1:0]   rd_d;
    logic [NRD-1:0]             rd_b;

    regfile_wr_merge #(
        .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_merge (
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy),
        .wdata(wdata), .hit(hit), .busy_nxt(busy_nxt)
    );

    // Out-of-range addresses and a hardwired register 0 match nothing and read as 0/0.
    always_comb begin
        rd_d = '0;
        rd_b = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (rd_addr[p] == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
                    rd_d[p] = (BYPASS != 0 && hit[r]) ? wdata[r] : regs[r];
                    rd_b[p] = (BYPASS != 0) ? busy_nxt[r] : busy[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            busy    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (hit[r]) regs[r] <= wdata[r];
            end
            busy <= busy_nxt;
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p] <= rd_d[p];
                    rd_busy[p] <= rd_b[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of two configurations sharing one stimulus stream.
// dut_a: 32 regs, zero register, bypass; dut_b: 24 regs, ordinary r0, read-first. Both have 2 write ports.
module tb_regfile_mp;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       rd_en;
    logic [1:0][4:0]  rd_addr;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             alloc_en;
    logic [4:0]       alloc_addr;
    logic [1:0][31:0] a_data, b_data;
    logic [1:0]       a_busy, b_busy;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_busy(a_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );
    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_busy(b_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1; wr_addr[p] = a; wr_data[p] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1; rd_addr[p] = a;
    endtask

    initial begin
        idle();
        #12;
        chk("reset a data", a_data[0], 32'h0);
        chk("reset b data", b_data[0], 32'h0);
        chk("reset a busy", 32'(a_busy), 32'h0);
        chk("reset b busy", 32'(b_busy), 32'h0);
        rst_n = 1'b1;
        cyc();
        // reset mid-traffic
        idle(); wr(0, 5'd5, 32'hDEADBEEF); cyc();
        idle(); rd(0, 5'd5); cyc();
        chk("r5 a", a_data[0], 32'hDEADBEEF);
        chk("r5 b", b_data[0], 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst a", a_data[0], 32'h0);
        chk("async rst b", b_data[0], 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("r5 after rst a", a_data[0], 32'h0);
        chk("r5 after rst b", b_data[0], 32'h0);
        // zero register: write + alloc r0
        idle(); wr(0, 5'd0, 32'h1234); alloc_en = 1'b1; alloc_addr = 5'd0; cyc();
        idle(); rd(0, 5'd0); cyc();
        chk("r0 a data", a_data[0], 32'h0);
        chk("r0 a busy", 32'(a_busy[0]), 32'h0);
        chk("r0 b data", b_data[0], 32'h1234);
        chk("r0 b busy", 32'(b_busy[0]), 32'h1);
        // bypass vs read-first
        idle(); wr(0, 5'd7, 32'h11111111); cyc();
        idle(); wr(0, 5'd7, 32'hA5A5A5A5); rd(1, 5'd7); cyc();
        chk("byp a", a_data[1], 32'hA5A5A5A5);
        chk("byp b old", b_data[1], 32'h11111111);
        idle(); rd(1, 5'd7); cyc();
        chk("r7 a", a_data[1], 32'hA5A5A5A5);
        chk("r7 b", b_data[1], 32'hA5A5A5A5);
        // write conflict: port 1 wins
        idle(); wr(0, 5'd3, 32'd1); wr(1, 5'd3, 32'd2); rd(0, 5'd3); cyc();
        chk("conf byp a", a_data[0], 32'd2);
        chk("conf old b", b_data[0], 32'd0);
        idle(); rd(0, 5'd3); cyc();
        chk("conf a", a_data[0], 32'd2);
        chk("conf b", b_data[0], 32'd2);
        // scoreboard on r9
        idle(); alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 5'd9); cyc();
        chk("alloc byp a busy", 32'(a_busy[0]), 32'h1);
        chk("alloc old b busy", 32'(b_busy[0]), 32'h0);
        idle(); rd(0, 5'd9); cyc();
        chk("alloc a busy", 32'(a_busy[0]), 32'h1);
        chk("alloc b busy", 32'(b_busy[0]), 32'h1);
        idle(); wr(0, 5'd9, 32'h55); rd(0, 5'd9); cyc();
        chk("wr55 byp a data", a_data[0], 32'h55);
        chk("wr55 byp a busy", 32'(a_busy[0]), 32'h0);
        chk("wr55 old b data", b_data[0], 32'h0);
        chk("wr55 old b busy", 32'(b_busy[0]), 32'h1);
        idle(); rd(0, 5'd9); cyc();
        chk("wr55 b data", b_data[0], 32'h55);
        chk("wr55 b busy", 32'(b_busy[0]), 32'h0);
        idle(); wr(1, 5'd9, 32'h66); alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 5'd9); cyc();
        chk("wa66 byp a data", a_data[0], 32'h66);
        chk("wa66 byp a busy", 32'(a_busy[0]), 32'h1);
        idle(); rd(0, 5'd9); cyc();
        chk("wa66 b data", b_data[0], 32'h66);
        chk("wa66 b busy", 32'(b_busy[0]), 32'h1);
        // bounds: 30 is valid in dut_a, invalid in dut_b (24 regs)
        idle(); wr(0, 5'd30, 32'hBAD); alloc_en = 1'b1; alloc_addr = 5'd30; cyc();
        idle(); rd(0, 5'd30); rd(1, 5'd6); cyc();
        chk("a30 a data", a_data[0], 32'hBAD);
        chk("a30 a busy", 32'(a_busy[0]), 32'h1);
        chk("a30 b data", b_data[0], 32'h0);
        chk("a30 b busy", 32'(b_busy[0]), 32'h0);
        chk("r6 b alias", b_data[1], 32'h0);
        // hold while rd_en is low
        idle(); rd(0, 5'd7); cyc();
        idle(); rd_addr[0] = 5'd9; cyc();
        chk("hold a data", a_data[0], 32'hA5A5A5A5);
        chk("hold b data", b_data[0], 32'hA5A5A5A5);
        chk("hold a busy", 32'(a_busy[0]), 32'h0);
        chk("hold b busy", 32'(b_busy[0]), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with synchronous read ports and per-register busy scoreboard bits. It generalises the core's 32x32 integer register file in width, depth, and read/write port count. Its added behaviours are selectable write-to-read bypass, an optional hardwired zero register, and scoreboard allocate/clear. It is the register storage for the issue stage of multi-issue and vector variants of the core.

## Interface
- `XLEN`, 32: data word width in bits.
- `NREGS`, 32: number of architectural registers (≥2; need not be a power of two).
- `NRD`, 2: number of read ports (≥1).
- `NWR`, 1: number of write ports (≥1).
- `ZERO_REG`, 1: 1 = register 0 reads as zero and ignores writes and allocs; 0 = register 0 is ordinary.
- `BYPASS`, 1: 1 = write-first reads; 0 = read-first reads.
- Derived: `AW` = `$clog2(NREGS)`.
- `clk`  in  1: clock. All state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rd_en`  in  [NRD]: read enable per port.
- `rd_addr`  in  [NRD][AW]: read address per port.
- `rd_data`  out  [NRD][XLEN]: registered read data.
- `rd_busy`  out  [NRD]: registered busy bit of the addressed register.
- `wr_en`  in  [NWR]: write enable per port.
- `wr_addr`  in  [NWR][AW]: write address per port.
- `wr_data`  in  [NWR][XLEN]: write data per port.
- `alloc_en`  in  1: mark a register busy (pending producer).
- `alloc_addr`  in  [AW]: register to mark busy.

## Operation
- Storage: `NREGS` x `XLEN` data array and `NREGS` busy bits.
- Reset (`rst_n` = 0, any time, mid-operation included) immediately clears:
  - all data registers and busy bits to 0;
  - `rd_data` to 0 and `rd_busy` to 0.
- Write: at each edge, for each port with `wr_en` = 1 and a valid address, `regs[wr_addr]` takes `wr_data` and its busy bit clears.
- Write conflict: if several ports write the same register in one cycle, the highest-indexed port wins.
- Alloc: when `alloc_en` = 1 and the address is valid, the busy bit sets. If alloc and a write target the same register in one cycle, the data updates and the busy bit ends set (alloc wins).
- Address validity:
  - Addresses ≥ `NREGS` are invalid. Writes and allocs to them are ignored; reads from them return data 0 and busy 0.
  - With `ZERO_REG` = 1, register 0 behaves as invalid, except reads return 0/0 as a defined value.
- Read: for each port with `rd_en` = 1, `rd_data`/`rd_busy` load the addressed register's data and busy bit at the edge. With `rd_en` = 0 the port holds its previous output.
- `BYPASS` = 1: a read sees the same-edge update, i.e. winning write data and the post-update busy bit (alloc/write rules applied).
- `BYPASS` = 0: a read sees pre-edge contents.
- Read ports are independent; any number may address the same register.

## Timing
- Read latency: 1 cycle. Address and enable sampled at edge N; data valid after edge N until the next enabled read.
- Write-to-read: a write at edge N is visible to reads sampled at edge N+1 in both modes, and at edge N itself only when `BYPASS` = 1.
- Busy visibility: an alloc at edge N shows `rd_busy` = 1 for reads at N+1 (and at N when `BYPASS` = 1).
- No handshake and no stalls; every input is sampled every cycle.
- Reset deassertion: the first active edge after `rst_n` rises is the first operational edge.

## Structure
- Shared package `regfile_pkg`: default constants `XLEN_DEF`, `NREGS_DEF`, `NRD_DEF`, `NWR_DEF`, plus the `word_t`/`addr_t` typedefs for the default configuration.
- Sub-module `regfile_wr_merge` (combinational): resolves per-register next data, write-hit, and next busy from all write ports and alloc, including port priority and validity masking. It is shared by the storage update and the bypass path so both use identical rules.
- Top: storage array, busy vector, and `NRD` registered read muxes.

## Test plan
- Reset mid-traffic: write 0xDEADBEEF to r5, read r5, pull `rst_n` low asynchronously between edges → `rd_data` = 0 immediately; a read of r5 after release returns 0.
- Zero register (`ZERO_REG` = 1): write 0x1234 to r0 and alloc r0, then read r0 → data 0, busy 0. With `ZERO_REG` = 0 the same sequence → 0x1234, busy 1.
- Bypass: write r7 = 0xA5A5A5A5 and read r7 in the same cycle → `BYPASS` = 1 gives 0xA5A5A5A5; `BYPASS` = 0 gives the old value, then 0xA5A5A5A5 on the next read.
- Write conflict (`NWR` = 2): port0 writes r3 = 1 and port1 writes r3 = 2 in the same cycle → r3 reads 2.
- Scoreboard: alloc r9 → `rd_busy` = 1; write r9 = 0x55 → busy 0, data 0x55; alloc plus write r9 = 0x66 in the same cycle → busy 1, data 0x66.
- Bounds and hold (`NREGS` = 24): write address 30, then read address 30 → 0/0 with no array change. With `rd_en` = 0 while the address changes, `rd_data` holds its previous value.
